tlb_ctrl: RTL and testbench

- Sequencing controller for the 4-way set-associative TLB: owns the entry arrays (NUM_SETS x NUM_WAYS of valid/vpn/ppn/perms), accepts translation requests, and performs lookup with tag compare on the full 20-bit VPN.
- On a miss it runs a single-level page-table walk over a memory request/response port, refills a victim way, and replays the lookup.
- Also handles global flush and maintains hit/miss statistics.
- Sits between the core load/store path and the memory system.

---
 rtl/tlb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
// 4-way set-associative TLB controller: lookup, single-level page-table walk,
// round-robin refill with replay, global flush, and hit/miss statistics.
module tlb_ctrl #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned NUM_SETS       = 2**SET_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_access_type,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic        resp_perm_fault,
  output logic        resp_page_fault,
  input  logic [31:0] ptbr,
  output logic        ptw_req_valid,
  input  logic        ptw_req_ready,
  output logic [31:0] ptw_req_addr,
  input  logic        ptw_resp_valid,
  input  logic [31:0] ptw_resp_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);
  localparam int unsigned VPN_W    = 20;
  localparam int unsigned PPN_W    = 20;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_REFILL, S_RESP
  } state_t;

  state_t                                   state;
  logic [31:0]                              vaddr_q;
  logic                                     acc_q;
  logic                                     flush_pending;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]        valid_q;
  logic [NUM_SETS-1:0][WAY_BITS-1:0]        rr_ptr;
  logic [PPN_W-1:0]                         pte_ppn_q;
  logic [1:0]                               pte_perms_q;

  logic [VPN_W-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0] ppn_q  [NUM_SETS][NUM_WAYS];
  logic [1:0]       perm_q [NUM_SETS][NUM_WAYS];

  logic [VPN_W-1:0]          vpn;
  logic [SET_INDEX_BITS-1:0] set_idx;
  logic                      hit;
  logic [WAY_BITS-1:0]       hit_way;
  logic                      has_invalid;
  logic [WAY_BITS-1:0]       victim_way;
  logic [1:0]                hit_perms;
  logic                      perm_ok;
  logic                      unused_pte_bits;

  assign vpn             = vaddr_q[31:12];
  assign set_idx         = vaddr_q[12 +: SET_INDEX_BITS];
  assign hit_perms       = perm_q[set_idx][hit_way];
  assign perm_ok         = hit_perms[acc_q];
  assign unused_pte_bits = ^ptw_resp_data[11:3];

  assign req_ready = (state == S_IDLE) && !flush_pending && !flush;
  assign busy      = (state != S_IDLE) || flush_pending;

  // Tag compare; the lowest-index matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (!hit && valid_q[set_idx][w] && (tag_q[set_idx][w] == vpn)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    has_invalid = 1'b0;
    victim_way  = rr_ptr[set_idx];
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (!has_invalid && !valid_q[set_idx][w]) begin
        has_invalid = 1'b1;
        victim_way  = WAY_BITS'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_REFILL) begin
      tag_q[set_idx][victim_way]  <= vpn;
      ppn_q[set_idx][victim_way]  <= pte_ppn_q;
      perm_q[set_idx][victim_way] <= pte_perms_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      vaddr_q         <= '0;
      acc_q           <= 1'b0;
      flush_pending   <= 1'b0;
      valid_q         <= '0;
      rr_ptr          <= '0;
      pte_ppn_q       <= '0;
      pte_perms_q     <= '0;
      resp_valid      <= 1'b0;
      resp_paddr      <= '0;
      resp_perm_fault <= 1'b0;
      resp_page_fault <= 1'b0;
      ptw_req_valid   <= 1'b0;
      ptw_req_addr    <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
    end else begin
      if (flush && (state != S_IDLE)) flush_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush || flush_pending) begin
            valid_q       <= '0;
            rr_ptr        <= '0;
            flush_pending <= 1'b0;
          end else if (req_valid) begin
            vaddr_q <= req_vaddr;
            acc_q   <= req_access_type;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_count       <= hit_count + 32'd1;
            resp_valid      <= 1'b1;
            resp_paddr      <= perm_ok ? {ppn_q[set_idx][hit_way], vaddr_q[11:0]} : 32'd0;
            resp_perm_fault <= !perm_ok;
            resp_page_fault <= 1'b0;
            state           <= S_RESP;
          end else begin
            miss_count    <= miss_count + 32'd1;
            ptw_req_valid <= 1'b1;
            ptw_req_addr  <= ptbr + 32'({vpn, 2'b00});
            state         <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (ptw_req_ready) begin
            ptw_req_valid <= 1'b0;
            state         <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_data[0]) begin
              pte_ppn_q   <= ptw_resp_data[31:12];
              pte_perms_q <= ptw_resp_data[2:1];
              state       <= S_REFILL;
            end else begin
              resp_valid      <= 1'b1;
              resp_paddr      <= '0;
              resp_perm_fault <= 1'b0;
              resp_page_fault <= 1'b1;
              state           <= S_RESP;
            end
          end
        end
        S_REFILL: begin
          valid_q[set_idx][victim_way] <= 1'b1;
          if (!has_invalid) rr_ptr[set_idx] <= rr_ptr[set_idx] + WAY_BITS'(1);
          state <= S_LOOKUP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid      <= 1'b0;
            resp_paddr      <= '0;
            resp_perm_fault <= 1'b0;
            resp_page_fault <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: expected responses are queued when a request is
// driven and compared when the controller answers.
module tb_tlb_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_access_type;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_ready, resp_perm_fault, resp_page_fault;
  logic [31:0] resp_paddr, ptbr;
  logic        ptw_req_valid, ptw_req_ready, ptw_resp_valid;
  logic [31:0] ptw_req_addr, ptw_resp_data;
  logic        flush, busy;
  logic [31:0] hit_count, miss_count;

  tlb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_access_type(req_access_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_perm_fault(resp_perm_fault), .resp_page_fault(resp_page_fault),
    .ptbr(ptbr),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_addr(ptw_req_addr),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_data(ptw_resp_data),
    .flush(flush), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [31:0] paddr;
    logic        pf;
    logic        pgf;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pt [logic [19:0]];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pte5(input logic [19:0] v);
    return {v ^ 20'hF0F0F, 12'h007};
  endfunction

  // One translation; exp_miss selects whether a walk is expected and which PTE answers it.
  task automatic xlate(input logic [31:0] va, input logic wr, input bit exp_miss,
                       input logic [31:0] pte, input bit flush_walk);
    exp_t        e, got;
    logic [19:0] v;
    logic [31:0] used;
    logic [1:0]  pm;
    int          n, lat, dly;
    bit          walk_seen;
    v    = va[31:12];
    used = exp_miss ? pte : pt[v];
    pm   = used[2:1];
    e.pgf   = !used[0];
    e.pf    = used[0] && !pm[wr];
    e.paddr = (used[0] && pm[wr]) ? {used[31:12], va[11:0]} : 32'h0;
    e.lat   = exp_miss ? 3 : 2;
    sb.push_back(e);
    if (exp_miss) begin
      exp_misses++;
      if (pte[0]) begin pt[v] = pte; exp_hits++; end
      else pt.delete(v);
    end else begin
      exp_hits++;
    end

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_vaddr = va; req_access_type = wr;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (exp_miss) begin
      n = 0;
      while (!ptw_req_valid && n < 10) begin @(negedge clk); n++; end
      check("ptw_req_seen", ptw_req_valid, 1);
      check("ptw_req_addr", ptw_req_addr, ptbr + {10'b0, va[31:12], 2'b00});
      dly = $urandom_range(0, 2);
      repeat (dly) begin
        @(negedge clk);
        check("ptw_req_stable", ptw_req_addr, ptbr + {10'b0, va[31:12], 2'b00});
      end
      ptw_req_ready = 1'b1;
      @(negedge clk);
      ptw_req_ready = 1'b0;
      check("ptw_req_drop", ptw_req_valid, 0);
      repeat (2) @(negedge clk);
      if (flush_walk) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy_in_walk", busy, 1);
      end
      ptw_resp_valid = 1'b1; ptw_resp_data = pte;
      @(negedge clk);
      ptw_resp_valid = 1'b0; ptw_resp_data = 32'h0;
      while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    end else begin
      walk_seen = 1'b0;
      while (!resp_valid && lat < 20) begin
        if (ptw_req_valid) walk_seen = 1'b1;
        @(negedge clk); lat++;
      end
      check("hit_no_walk", 32'(walk_seen), 0);
    end
    check("resp_arrived", resp_valid, 1);
    got = sb.pop_front();
    check("resp_paddr", resp_paddr, got.paddr);
    check("resp_perm_fault", resp_perm_fault, got.pf);
    check("resp_page_fault", resp_page_fault, got.pgf);
    if (!got.pgf) check("resp_latency", 32'(lat), 32'(got.lat));
    @(negedge clk);
    check("resp_hold", resp_valid, 1);
    check("resp_hold_paddr", resp_paddr, got.paddr);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_clear", resp_valid, 0);
    check("busy_after", busy, 32'(flush_walk));
    if (flush_walk) begin
      check("req_ready_flushing", req_ready, 0);
      @(negedge clk);
      check("busy_flushed", busy, 0);
    end
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_access_type = 1'b0;
    resp_ready = 1'b0; ptbr = 32'h0010_0000; ptw_req_ready = 1'b0;
    ptw_resp_valid = 1'b0; ptw_resp_data = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_ptw_req_valid", ptw_req_valid, 0);
    check("rst_ptw_req_addr", ptw_req_addr, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);

    // Cold miss, walk, refill, replay; then the same page hits
    xlate(32'h1234_5678, 1'b0, 1'b1, 32'h5432_1007, 1'b0);
    xlate(32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);

    // Flush beats a simultaneous request
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_vaddr = 32'h1234_5678;
    #1 check("req_ready_vs_flush", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check("flush_no_lookup", busy, 0);
    check("flush_no_resp", resp_valid, 0);

    // Fill set 5, then two round-robin replacements (ways 0 then 1)
    for (int i = 0; i < 6; i++)
      xlate({20'h00005 + 20'(i) * 20'h10000, 12'h4A8}, 1'b0, 1'b1, pte5(20'h00005 + 20'(i) * 20'h10000), 1'b0);
    for (int i = 2; i < 6; i++)
      xlate({20'h00005 + 20'(i) * 20'h10000, 12'h4A8}, 1'b0, 1'b0, 32'h0, 1'b0);
    xlate(32'h0000_54A8, 1'b0, 1'b1, pte5(20'h00005), 1'b0);
    xlate(32'h1000_54A8, 1'b0, 1'b1, pte5(20'h10005), 1'b0);
    xlate(32'h4000_54A8, 1'b0, 1'b0, 32'h0, 1'b0);

    // Write to read-only page, read of it, then invalid PTE twice
    xlate(32'h6666_6789, 1'b1, 1'b1, 32'h6666_6003, 1'b0);
    xlate(32'h6666_6789, 1'b0, 1'b0, 32'h0, 1'b0);
    xlate(32'h7777_7ABC, 1'b0, 1'b1, 32'h0, 1'b0);
    xlate(32'h7777_7ABC, 1'b1, 1'b1, 32'h0, 1'b0);

    // Flush during walk: walk completes, then everything is invalid
    xlate(32'h0ABC_1234, 1'b0, 1'b1, 32'h0ABC_1007, 1'b1);
    xlate(32'h4000_54A8, 1'b0, 1'b1, pte5(20'h40005), 1'b0);
    xlate(32'h0ABC_1234, 1'b1, 1'b1, 32'h0ABC_1007, 1'b0);

    // Reset in the middle of a walk
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = 32'h0DEA_D123; req_access_type = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!ptw_req_valid && n < 10) begin @(negedge clk); n++; end
    check("rst_walk_req", ptw_req_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_ptw_drop", ptw_req_valid, 0);
    check("rst_mid_hits", hit_count, 0);
    check("rst_mid_misses", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    check("rst_rel_req_ready", req_ready, 1);
    check("rst_rel_busy", busy, 0);
    ptw_resp_valid = 1'b1; ptw_resp_data = 32'h0DEA_D007;
    @(negedge clk);
    ptw_resp_valid = 1'b0; ptw_resp_data = 32'h0;
    @(negedge clk);
    check("stray_ptw_busy", busy, 0);
    check("stray_ptw_resp", resp_valid, 0);
    xlate(32'h1234_5678, 1'b0, 1'b1, 32'h5432_1007, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
